// File: rtl/core_run_pkg.sv
// Shared FSM encoding, termination status codes and helpers for the core run controller.
package core_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_e;

    typedef enum logic [1:0] {
        STAT_NONE    = 2'b00,
        STAT_HALT    = 2'b01,
        STAT_TIMEOUT = 2'b10,
        STAT_STALL   = 2'b11
    } run_status_e;

    localparam int STALL_W   = 16;
    localparam int MAX_CORES = 8;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_set(input logic [MAX_CORES-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = MAX_CORES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pc_stall_det.sv
// Per-core stall detector: counts consecutive RUN cycles in which the core PC did not move.
module pc_stall_det
    import core_run_pkg::*;
#(
    parameter int PC_W = 24
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               enable,
    input  logic [PC_W-1:0]    pc,
    input  logic [STALL_W-1:0] stall_limit,
    output logic               stall
);

    logic [PC_W-1:0]    pc_prev_r;
    logic               pc_valid_r;
    logic [STALL_W-1:0] stall_cnt_r;
    logic               pc_same_s;

    // The first sampled PC of a run has no predecessor and counts as a change.
    assign pc_same_s = pc_valid_r && (pc == pc_prev_r);

    // PC history and saturating unchanged-cycle counter.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            pc_prev_r   <= {PC_W{1'b0}};
            pc_valid_r  <= 1'b0;
            stall_cnt_r <= {STALL_W{1'b0}};
        end else if (enable) begin
            pc_prev_r  <= pc;
            pc_valid_r <= 1'b1;
            if (!pc_same_s) begin
                stall_cnt_r <= {STALL_W{1'b0}};
            end else if (stall_cnt_r != {STALL_W{1'b1}}) begin
                stall_cnt_r <= stall_cnt_r + STALL_W'(1);
            end
        end
    end

    assign stall = (stall_limit != {STALL_W{1'b0}}) && (stall_cnt_r >= stall_limit);

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: holds cores in reset, runs them, and records why and when the run ended.
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int N_CORES      = 2,
    parameter int PC_W         = 24,
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 4,
    parameter int HALT_ALL     = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [CNT_W-1:0]        max_cycles,
    input  logic [STALL_W-1:0]      stall_limit,
    input  logic [N_CORES-1:0]      halt_i,
    input  logic [N_CORES*PC_W-1:0] pc_i,
    output logic [N_CORES-1:0]      core_resetn_o,
    output logic                    running_o,
    output logic                    done_o,
    output logic [1:0]              status_o,
    output logic [2:0]              cause_core_o,
    output logic [N_CORES-1:0]      halted_mask_o,
    output logic [CNT_W-1:0]        cycle_count_o
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    run_state_e         state_r;
    run_state_e         state_nxt_s;
    logic [RC_W-1:0]    rst_cnt_r;
    run_status_e        status_r;
    logic [2:0]         cause_r;
    logic [N_CORES-1:0] mask_r;
    logic [CNT_W-1:0]   count_r;

    logic               enter_rst_s;
    logic               in_run_s;
    logic [N_CORES-1:0] all_seen_s;
    logic [N_CORES-1:0] stall_raw_s;
    logic [N_CORES-1:0] stall_vec_s;
    logic               halt_term_s;
    logic               timeout_term_s;
    logic               term_s;
    run_status_e        term_status_s;
    logic [2:0]         term_cause_s;

    assign in_run_s       = (state_r == ST_RUN);
    assign all_seen_s     = mask_r | halt_i;
    assign halt_term_s    = (HALT_ALL != 0) ? (&all_seen_s) : (|halt_i);
    // A core that has already halted keeps a frozen PC, which is not a stall.
    assign stall_vec_s    = stall_raw_s & ~all_seen_s;
    assign timeout_term_s = (max_cycles != {CNT_W{1'b0}}) && (count_r >= max_cycles);

    for (genvar g = 0; g < N_CORES; g++) begin : g_core
        pc_stall_det #(
            .PC_W(PC_W)
        ) u_det (
            .clk        (clk),
            .resetn     (resetn),
            .clear      (enter_rst_s),
            .enable     (in_run_s),
            .pc         (pc_i[g*PC_W +: PC_W]),
            .stall_limit(stall_limit),
            .stall      (stall_raw_s[g])
        );
    end

    // Next-state selection; a run (re)starts only from IDLE or DONE.
    always_comb begin
        state_nxt_s = state_r;
        enter_rst_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_RST;
                    enter_rst_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RST: begin
                if (rst_cnt_r == RC_W'(RESET_CYCLES - 1)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_RST;
                end
            end
            ST_RUN: begin
                if (term_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Termination arbitration: halt beats stall beats timeout.
    always_comb begin
        term_s        = 1'b0;
        term_status_s = STAT_NONE;
        term_cause_s  = 3'd0;
        if (in_run_s) begin
            if (halt_term_s) begin
                term_s        = 1'b1;
                term_status_s = STAT_HALT;
                term_cause_s  = lowest_set(MAX_CORES'(halt_i));
            end else if (|stall_vec_s) begin
                term_s        = 1'b1;
                term_status_s = STAT_STALL;
                term_cause_s  = lowest_set(MAX_CORES'(stall_vec_s));
            end else if (timeout_term_s) begin
                term_s        = 1'b1;
                term_status_s = STAT_TIMEOUT;
                term_cause_s  = 3'd0;
            end else begin
                term_s        = 1'b0;
            end
        end else begin
            term_s = 1'b0;
        end
    end

    // State, reset-hold counter and run bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            rst_cnt_r <= {RC_W{1'b0}};
            status_r  <= STAT_NONE;
            cause_r   <= 3'd0;
            mask_r    <= {N_CORES{1'b0}};
            count_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (enter_rst_s) begin
                rst_cnt_r <= {RC_W{1'b0}};
                status_r  <= STAT_NONE;
                cause_r   <= 3'd0;
                mask_r    <= {N_CORES{1'b0}};
                count_r   <= {CNT_W{1'b0}};
            end else if (state_r == ST_RST) begin
                rst_cnt_r <= rst_cnt_r + RC_W'(1);
            end else if (in_run_s) begin
                if (count_r != {CNT_W{1'b1}}) begin
                    count_r <= count_r + CNT_W'(1);
                end
                mask_r <= mask_r | halt_i;
                if (term_s) begin
                    status_r <= term_status_s;
                    cause_r  <= term_cause_s;
                end
            end
        end
    end

    assign core_resetn_o = {N_CORES{(state_r == ST_RUN) || (state_r == ST_DONE)}};
    assign running_o     = in_run_s;
    assign done_o        = (state_r == ST_DONE);
    assign status_o      = status_r;
    assign cause_core_o  = cause_r;
    assign halted_mask_o = mask_r;
    assign cycle_count_o = count_r;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench: one controller in first-halt mode and one in all-halt mode share stimulus.
module tb_core_run_ctrl;

    localparam int N    = 2;
    localparam int PC_W = 24;
    localparam int RC   = 4;
    localparam int MAXK = 200;

    typedef struct {
        logic [1:0]  status;
        logic [2:0]  cause;
        logic [31:0] count;
        logic [1:0]  mask;
    } exp_t;

    logic            clk = 1'b0;
    logic            resetn, start;
    logic [31:0]     max_cycles;
    logic [15:0]     stall_limit;
    logic [N-1:0]    halt_i;
    logic [N*PC_W-1:0] pc_i;

    logic [N-1:0] crn_a, crn_b, mask_a, mask_b;
    logic         run_a, run_b, done_a, done_b;
    logic [1:0]   stat_a, stat_b;
    logic [2:0]   cause_a, cause_b;
    logic [31:0]  cnt_a, cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic pd_a = 1'b0;
    logic pd_b = 1'b0;

    logic [N-1:0]    h_tab  [MAXK];
    logic [PC_W-1:0] pc_tab [MAXK][N];
    int mc, sl;

    always #5 clk = ~clk;

    core_run_ctrl #(.N_CORES(N), .PC_W(PC_W), .CNT_W(32), .RESET_CYCLES(RC), .HALT_ALL(0)) dut_a (
        .clk(clk), .resetn(resetn), .start(start), .max_cycles(max_cycles),
        .stall_limit(stall_limit), .halt_i(halt_i), .pc_i(pc_i),
        .core_resetn_o(crn_a), .running_o(run_a), .done_o(done_a), .status_o(stat_a),
        .cause_core_o(cause_a), .halted_mask_o(mask_a), .cycle_count_o(cnt_a));

    core_run_ctrl #(.N_CORES(N), .PC_W(PC_W), .CNT_W(32), .RESET_CYCLES(RC), .HALT_ALL(1)) dut_b (
        .clk(clk), .resetn(resetn), .start(start), .max_cycles(max_cycles),
        .stall_limit(stall_limit), .halt_i(halt_i), .pc_i(pc_i),
        .core_resetn_o(crn_b), .running_o(run_b), .done_o(done_b), .status_o(stat_b),
        .cause_core_o(cause_b), .halted_mask_o(mask_b), .cycle_count_o(cnt_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the run cycle by cycle applying the termination rules directly.
    function automatic exp_t model(input bit halt_all, output bit ended);
        exp_t       e;
        logic [1:0] seen;
        logic [1:0] h;
        int         unchanged [N];
        int         stall_core;
        bit         halt_hit, tmo;
        e = '{status: 2'b00, cause: 3'd0, count: 32'd0, mask: 2'b00};
        seen = 2'b00;
        ended = 1'b0;
        for (int i = 0; i < N; i++) unchanged[i] = 0;
        for (int k = 0; k < MAXK; k++) begin
            h = h_tab[k];
            halt_hit = halt_all ? ((seen | h) == 2'b11) : (h != 2'b00);
            stall_core = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (sl != 0 && !seen[i] && !h[i] && unchanged[i] >= sl) stall_core = i;
            end
            tmo = (mc != 0) && (k >= mc);
            seen = seen | h;
            if (halt_hit || stall_core >= 0 || tmo) begin
                e.count = 32'(k + 1);
                e.mask  = seen;
                if (halt_hit) begin
                    e.status = 2'b01;
                    for (int i = N - 1; i >= 0; i--) if (h[i]) e.cause = 3'(i);
                end else if (stall_core >= 0) begin
                    e.status = 2'b11;
                    e.cause  = 3'(stall_core);
                end else begin
                    e.status = 2'b10;
                    e.cause  = 3'd0;
                end
                ended = 1'b1;
                return e;
            end
            for (int i = 0; i < N; i++) begin
                if (k > 0 && pc_tab[k][i] == pc_tab[k-1][i]) unchanged[i]++;
                else unchanged[i] = 0;
            end
        end
        return e;
    endfunction

    task automatic build(input int hc0, input int hc1, input int fz0, input int fz1, input bit rnd);
        int hc [N];
        int fz [N];
        hc[0] = hc0; hc[1] = hc1; fz[0] = fz0; fz[1] = fz1;
        for (int k = 0; k < MAXK; k++) begin
            for (int i = 0; i < N; i++) begin
                h_tab[k][i] = (hc[i] >= 0) && (k >= hc[i]);
                if (k == 0) pc_tab[k][i] = PC_W'($urandom);
                else if ((fz[i] >= 0 && k > fz[i]) || (rnd && $urandom_range(0, 3) == 0))
                    pc_tab[k][i] = pc_tab[k-1][i];
                else pc_tab[k][i] = pc_tab[k-1][i] + 24'd4;
            end
        end
    endtask

    task automatic rand_inputs();
        halt_i = N'($urandom);
        pc_i   = (N*PC_W)'({$urandom, $urandom});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_crn_a"}, 32'(crn_a), 32'd0);     chk({tag, "_crn_b"}, 32'(crn_b), 32'd0);
        chk({tag, "_run_a"}, 32'(run_a), 32'd0);     chk({tag, "_run_b"}, 32'(run_b), 32'd0);
        chk({tag, "_done_a"}, 32'(done_a), 32'd0);   chk({tag, "_done_b"}, 32'(done_b), 32'd0);
        chk({tag, "_stat_a"}, 32'(stat_a), 32'd0);   chk({tag, "_stat_b"}, 32'(stat_b), 32'd0);
        chk({tag, "_cause_a"}, 32'(cause_a), 32'd0); chk({tag, "_cause_b"}, 32'(cause_b), 32'd0);
        chk({tag, "_mask_a"}, 32'(mask_a), 32'd0);   chk({tag, "_mask_b"}, 32'(mask_b), 32'd0);
        chk({tag, "_cnt_a"}, cnt_a, 32'd0);          chk({tag, "_cnt_b"}, cnt_b, 32'd0);
    endtask

    // Start pulse followed by the core-reset hold; a second start inside the hold is ignored.
    task automatic launch();
        @(posedge clk); #1;
        start = 1'b1; max_cycles = 32'(mc); stall_limit = 16'(sl);
        rand_inputs();
        @(posedge clk); #1;
        for (int i = 0; i < RC; i++) begin
            start = (i == 1);
            rand_inputs();
            @(negedge clk);
            chk("rst_hold_crn_a", 32'(crn_a), 32'd0);
            chk("rst_hold_crn_b", 32'(crn_b), 32'd0);
            if (i == 0) begin
                chk("rst_clear_cnt_a", cnt_a, 32'd0);           chk("rst_clear_cnt_b", cnt_b, 32'd0);
                chk("rst_clear_mask_a", 32'(mask_a), 32'd0);    chk("rst_clear_mask_b", 32'(mask_b), 32'd0);
                chk("rst_clear_stat_a", 32'(stat_a), 32'd0);    chk("rst_clear_stat_b", 32'(stat_b), 32'd0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic run_to_done(input exp_t ea, input exp_t eb);
        int kmax, kmin;
        kmax = (ea.count > eb.count) ? int'(ea.count) : int'(eb.count);
        kmin = (ea.count < eb.count) ? int'(ea.count) : int'(eb.count);
        for (int k = 0; k < kmax; k++) begin
            halt_i = h_tab[k];
            pc_i   = {pc_tab[k][1], pc_tab[k][0]};
            start  = (k == 1) && (kmin > 1);
            @(negedge clk);
            if (k == 0) begin
                chk("run_entry_a", 32'(run_a), 32'd1);     chk("run_entry_b", 32'(run_b), 32'd1);
                chk("run_crn_a", 32'(crn_a), 32'd3);       chk("run_crn_b", 32'(crn_b), 32'd3);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_by_deadline_a", 32'(done_a), 32'd1);
        chk("done_by_deadline_b", 32'(done_b), 32'd1);
        for (int j = 0; j < 3; j++) begin
            rand_inputs();
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("frozen_cnt_a", cnt_a, ea.count);            chk("frozen_cnt_b", cnt_b, eb.count);
        chk("frozen_mask_a", 32'(mask_a), 32'(ea.mask)); chk("frozen_mask_b", 32'(mask_b), 32'(eb.mask));
    endtask

    task automatic scenario(input int hc0, input int hc1, input int fz0, input int fz1,
                            input int mcv, input int slv, input bit rnd);
        exp_t ea, eb;
        bit   enda, endb;
        build(hc0, hc1, fz0, fz1, rnd);
        mc = mcv; sl = slv;
        ea = model(1'b0, enda);
        eb = model(1'b1, endb);
        if (!(enda && endb)) begin
            mc = 150;
            ea = model(1'b0, enda);
            eb = model(1'b1, endb);
        end
        qa.push_back(ea);
        qb.push_back(eb);
        launch();
        run_to_done(ea, eb);
    endtask

    // Monitor: each rising done is matched against the oldest expected termination.
    always @(negedge clk) begin
        if (done_a === 1'b1 && pd_a !== 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_done", 32'(done_a), 32'd0);
            else begin
                chk("a_status", 32'(stat_a), 32'(qa[0].status));
                chk("a_cause", 32'(cause_a), 32'(qa[0].cause));
                chk("a_count", cnt_a, qa[0].count);
                chk("a_mask", 32'(mask_a), 32'(qa[0].mask));
                chk("a_done_crn", 32'(crn_a), 32'd3);
                void'(qa.pop_front());
            end
        end
        if (done_b === 1'b1 && pd_b !== 1'b1) begin
            if (qb.size() == 0) chk("b_unexpected_done", 32'(done_b), 32'd0);
            else begin
                chk("b_status", 32'(stat_b), 32'(qb[0].status));
                chk("b_cause", 32'(cause_b), 32'(qb[0].cause));
                chk("b_count", cnt_b, qb[0].count);
                chk("b_mask", 32'(mask_b), 32'(qb[0].mask));
                chk("b_done_crn", 32'(crn_b), 32'd3);
                void'(qb.pop_front());
            end
        end
        pd_a <= done_a;
        pd_b <= done_b;
    end

    initial begin
        resetn = 1'b0; start = 1'b0; max_cycles = 32'd0; stall_limit = 16'd0;
        halt_i = '0; pc_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;
        resetn = 1'b1;

        // hc0, hc1, fz0, fz1, max_cycles, stall_limit, random PC repeats
        scenario(-1, 10, -1, -1, 120, 0, 1'b0);
        scenario(-1, -1, -1, -1, 50, 0, 1'b0);
        scenario(-1, -1, 3, -1, 0, 8, 1'b0);
        scenario(5, 20, -1, -1, 0, 0, 1'b0);
        scenario(30, -1, -1, -1, 30, 0, 1'b0);
        scenario(5, -1, -1, 0, 0, 4, 1'b0);
        scenario(-1, 7, 2, 2, 0, 6, 1'b0);

        // Reset in the middle of a run that would otherwise never end.
        build(-1, -1, -1, -1, 1'b1);
        mc = 0; sl = 0;
        launch();
        for (int k = 0; k < 7; k++) begin
            halt_i = 2'b00;
            pc_i   = {pc_tab[k][1], pc_tab[k][0]};
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("mid_run_reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int r = 0; r < 14; r++) begin
            scenario(($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 60)),
                     ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 60)),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1,
                     ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 100)),
                     ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 12)),
                     1'b1);
        end

        @(negedge clk);
        chk("queue_a_drained", 32'(qa.size()), 32'd0);
        chk("queue_b_drained", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 SHALL have parameter N_CORES, default 2, number of supervised cores (1..8).
REQ-002 SHALL have parameter PC_W, default 24, width of each core PC.
REQ-003 SHALL have parameter CNT_W, default 32, width of cycle counter and limit.
REQ-004 SHALL have parameter RESET_CYCLES, default 4, core-reset hold length in cycles (>=1).
REQ-005 SHALL have parameter HALT_ALL, default 0; 0 = done on first halt, 1 = done when all cores halted.
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-008 SHALL have port start  input  1  begin a run (pulse).
REQ-009 SHALL have port max_cycles  input  CNT_W  timeout limit; 0 = unlimited.
REQ-010 SHALL have port stall_limit  input  16  PC-unchanged limit; 0 = stall detection off.
REQ-011 SHALL have port halt_i  input  N_CORES  per-core halt.
REQ-012 SHALL have port pc_i  input  N_CORES*PC_W  packed per-core PC, core 0 in LSBs.
REQ-013 SHALL have port core_resetn_o  output  N_CORES  per-core active-low reset.
REQ-014 SHALL have port running_o  output  1  high in RUN.
REQ-015 SHALL have port done_o  output  1  high in DONE.
REQ-016 SHALL have port status_o  output  2  00 none, 01 halt, 10 timeout, 11 stall.
REQ-017 SHALL have port cause_core_o  output  3  core index that caused halt/stall termination.
REQ-018 SHALL have port halted_mask_o  output  N_CORES  sticky per-core halt record.
REQ-019 SHALL have port cycle_count_o  output  CNT_W  RUN cycles elapsed.

Function
REQ-020 SHALL implement FSM IDLE -> RST (on start) -> RUN (after RESET_CYCLES cycles) -> DONE; start in DONE -> RST; start in RST/RUN ignored.
REQ-021 SHALL drive core_resetn_o all-0 in IDLE and RST, all-1 in RUN and DONE.
REQ-022 SHALL clear cycle_count_o, halted_mask_o, status_o, cause_core_o, stall counters on entry to RST.
REQ-023 SHALL increment cycle_count_o by 1 every RUN cycle; frozen in DONE; saturates at all-ones.
REQ-024 SHALL set halted_mask_o[i] in any RUN cycle with halt_i[i]=1; bit stays set until next RST.
REQ-025 SHALL terminate on halt when HALT_ALL=0 and any halt_i high, or HALT_ALL=1 and (halted_mask_o | halt_i) all-ones.
REQ-026 SHALL terminate on timeout when max_cycles!=0 and cycle_count_o >= max_cycles in a RUN cycle.
REQ-027 SHALL keep per-core stall counter: reset when pc_i[i] differs from previous cycle's value, else increment; terminate on stall when counter reaches stall_limit for a non-halted core and stall_limit!=0.
REQ-028 SHALL resolve simultaneous terminations with priority halt > stall > timeout; cause_core_o = lowest-index qualifying core; 0 for timeout.
REQ-029 SHALL register termination: DONE, status_o, cause_core_o valid the cycle after the terminating RUN cycle.
REQ-030 SHALL ignore halt_i, pc_i outside RUN.

Reset
REQ-031 SHALL on resetn=0 at clk edge enter IDLE: core_resetn_o=0, running_o=0, done_o=0, status_o=00, cause_core_o=0, halted_mask_o=0, cycle_count_o=0, regardless of prior state.

Structure
REQ-032 SHALL place FSM state encoding and status codes in shared package core_run_pkg.
REQ-033 SHALL instantiate one sub-module pc_stall_det per core (PC register, 16-bit counter, stall flag).

Verification
REQ-034 SHALL cover: N_CORES=2, start, core1 halt_i at RUN cycle 10 -> status 01, cause_core 1, cycle_count 11, halted_mask 10.
REQ-035 SHALL cover: max_cycles=50, no halt, PCs changing -> status 10 at cycle_count 51, core_resetn_o stays 11.
REQ-036 SHALL cover: stall_limit=8, core0 PC frozen from RUN cycle 3 -> status 11, cause_core 0.
REQ-037 SHALL cover: HALT_ALL=1, core0 halts cycle 5, core1 cycle 20 -> DONE only after cycle 20, mask 11.
REQ-038 SHALL cover: halt and timeout same cycle -> status 01; resetn low mid-RUN -> all outputs to reset values next cycle.
REQ-039 SHALL cover: RESET_CYCLES=4 -> core_resetn_o low exactly 4 cycles after start; start in DONE restarts with cleared counters.
